// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3). Optional macro: BCD_AUTO_START_EN.
// Latency: digits and done are registered 9 cycles after the edge that samples start.
// Backpressure: none; start and bin are ignored while busy, so one conversion per 10 cycles at most.
module bin_to_bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] scratch;
    logic [7:0]  shift_reg;
    logic [2:0]  iter_cnt;
    logic [11:0] scratch_adj;
    logic        go;

`ifdef BCD_AUTO_START_EN
    logic [7:0] last_bin;
    assign go = start || (bin != last_bin);
`else
    assign go = start;
`endif

    // Nibbles >= 5 would become >= 10 after the shift; pre-correct by 3.
    always_comb begin
        scratch_adj = scratch;
        if (scratch[3:0]  >= 4'd5) scratch_adj[3:0]  = scratch[3:0]  + 4'd3;
        if (scratch[7:4]  >= 4'd5) scratch_adj[7:4]  = scratch[7:4]  + 4'd3;
        if (scratch[11:8] >= 4'd5) scratch_adj[11:8] = scratch[11:8] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hundreds  <= 8'd0;
            tens      <= 8'd0;
            ones      <= 8'd0;
            scratch   <= 12'd0;
            shift_reg <= 8'd0;
            iter_cnt  <= 3'd0;
`ifdef BCD_AUTO_START_EN
            last_bin  <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        shift_reg <= bin;
                        scratch   <= 12'd0;
                        iter_cnt  <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
`ifdef BCD_AUTO_START_EN
                        last_bin  <= bin;
`endif
                    end
                end
                SHIFT: begin
                    scratch   <= {scratch_adj[10:0], shift_reg[7]};
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    iter_cnt  <= iter_cnt + 3'd1;
                    if (iter_cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hundreds <= {4'h0, scratch[11:8]};
                    tens     <= {4'h0, scratch[7:4]};
                    ones     <= {4'h0, scratch[3:0]};
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes decimal digits and done cycle; a negedge monitor checks them.
module tb_bin_to_bcd_seq;

    typedef struct {
        int         cyc;
        logic [7:0] h;
        logic [7:0] t;
        logic [7:0] o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bin = 8'd0;
    logic       busy, done;
    logic [7:0] hundreds, tens, ones;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    logic       rst_seen = 1'b1;
    logic [7:0] last_h = 8'd0, last_t = 8'd0, last_o = 8'd0;

    bin_to_bcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Reference: plain decimal arithmetic; done expected 10 negedges after the drive point.
    task automatic push_exp(input logic [7:0] b);
        exp_t e;
        int   v;
        v     = b;
        e.cyc = cyc + 10;
        e.h   = 8'(v / 100);
        e.t   = 8'((v / 10) % 10);
        e.o   = 8'(v % 10);
        exp_q.push_back(e);
    endtask

    task automatic conv(input logic [7:0] b, input bit noise);
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        push_exp(b);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: busy=%b required 1 (bin=%0d)", busy, b);
        end
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk);
            if (noise) bin = 8'($urandom_range(0, 255));
            start = (noise && i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            checks++;
            if ({done, busy, hundreds, tens, ones} !== 26'd0) begin
                fails++;
                $display("FAIL reset_state: done=%b busy=%b digits=%0d,%0d,%0d required all 0",
                         done, busy, hundreds, tens, ones);
            end
            last_h = 8'd0; last_t = 8'd0; last_o = 8'd0;
        end else if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done pulse at cycle %0d with nothing pending", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL done_latency: done at cycle %0d required cycle %0d", cyc, e.cyc);
                end
                checks++;
                if ({hundreds, tens, ones} !== {e.h, e.t, e.o}) begin
                    fails++;
                    $display("FAIL digits: got %0d,%0d,%0d required %0d,%0d,%0d",
                             hundreds, tens, ones, e.h, e.t, e.o);
                end
                checks++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_at_done: busy=%b required 0", busy);
                end
                last_h = e.h; last_t = e.t; last_o = e.o;
            end
        end else begin
            checks++;
            if ({done, hundreds, tens, ones} !== {1'b0, last_h, last_t, last_o}) begin
                fails++;
                $display("FAIL digits_stable: done=%b digits=%0d,%0d,%0d required 0 and %0d,%0d,%0d",
                         done, hundreds, tens, ones, last_h, last_t, last_o);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                fails++;
                $display("FAIL missing_done: no done at cycle %0d required one", e.cyc);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
`ifdef BCD_AUTO_START_EN
        bin = 8'd150;
        start = 1'b0;
        push_exp(8'd150);
        repeat (30) @(negedge clk);
        conv(8'd37, 1'b0);
        repeat (20) @(negedge clk);
`else
        conv(8'd255, 1'b0);
        conv(8'd0,   1'b0);
        conv(8'd109, 1'b0);
        conv(8'd99,  1'b0);
        conv(8'd9,   1'b0);
        conv(8'd10,  1'b0);
        conv(8'd100, 1'b0);
        conv(8'd199, 1'b0);
        repeat (3) @(negedge clk);

        // Value captured at start wins over a later bin/start while busy.
        @(negedge clk);
        bin = 8'd42; start = 1'b1; push_exp(8'd42);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        bin = 8'd200; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-conversion: no done, digits back to zero, then a clean rerun.
        @(negedge clk);
        bin = 8'd77; start = 1'b1; push_exp(8'd77);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        repeat (14) @(negedge clk);
        conv(8'd77, 1'b0);
        repeat (2) @(negedge clk);

        // start held high: one conversion every 10 cycles.
        for (int k = 0; k < 3; k++) begin
            bin = 8'($urandom_range(0, 255));
            start = 1'b1;
            push_exp(bin);
            @(negedge clk);
            if (k == 2) start = 1'b0;
            for (int i = 1; i < 10; i++) begin
                @(negedge clk);
                if (!(k < 2 && i == 9)) bin = 8'($urandom_range(0, 255));
            end
        end
        repeat (3) @(negedge clk);

        repeat (30) conv(8'($urandom_range(0, 255)), 1'b1);
`endif
        repeat (15) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_at_end: %0d results outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-004 SHALL have port bin, input, 8 bits: unsigned binary value to convert (0..255), e.g. mines-remaining count.
REQ-005 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse when digit outputs update.
REQ-007 SHALL have port hundreds, output, 8 bits: BCD hundreds digit, upper 4 bits zero; drives a 7-segment decoder data input directly.
REQ-008 SHALL have port tens, output, 8 bits: BCD tens digit, upper 4 bits zero.
REQ-009 SHALL have port ones, output, 8 bits: BCD ones digit, upper 4 bits zero.

Function
REQ-010 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-011 SHALL, in IDLE with start=1, capture bin into a shift register, clear the 12-bit BCD scratch register, clear a 3-bit iteration counter, and go to SHIFT.
REQ-012 SHALL, in each SHIFT cycle, add 3 to every scratch nibble >= 5, then shift the {scratch, binary} register left by one, and increment the counter.
REQ-013 SHALL go from SHIFT to DONE after exactly 8 SHIFT cycles.
REQ-014 SHALL, on entry to DONE, load hundreds/tens/ones from the scratch nibbles and assert done for exactly one cycle; DONE SHALL then go to IDLE.
REQ-015 SHALL register done and the new digit values together: with start sampled at edge k, both become visible after edge k+9 (latency 9 cycles).
REQ-016 SHALL drive busy=1 exactly while in SHIFT or DONE, and busy=0 in IDLE.
REQ-017 SHALL ignore start and changes on bin while busy=1; the value captured at start is converted.
REQ-018 SHALL hold the digit outputs stable between done pulses; they SHALL change only on DONE entry or reset.
REQ-019 SHALL keep each digit output in 0..9 for every bin in 0..255; an output above 9 is a defect.
REQ-020 SHALL NOT back-to-back chain: start asserted continuously restarts one cycle after DONE, i.e. one conversion every 10 cycles.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, force state=IDLE, busy=0, done=0, and hundreds=tens=ones=0, and clear the scratch, shift and counter registers.
REQ-022 SHALL abort any conversion on reset mid-operation, without a done pulse and without updating the digit outputs from partial results.
REQ-023 SHALL give rst priority over start when both are asserted at the same edge.

Configuration
REQ-024 SHALL, with macro BCD_AUTO_START_EN defined, keep an 8-bit register last_bin (reset 0) that is updated with the captured value at each conversion start.
REQ-025 SHALL, with BCD_AUTO_START_EN defined, start a conversion in IDLE when bin != last_bin, exactly as if start=1; the start port stays functional.
REQ-026 SHALL, without BCD_AUTO_START_EN, start conversions only via start, and SHALL contain no last_bin register.

Verification
REQ-027 SHALL cover this scenario: reset asserted 2 cycles, then released -> hundreds=tens=ones=0, busy=0, done=0.
REQ-028 SHALL cover this scenario: bin=8'd255, start pulse at edge k -> busy=1 after edge k, done=1 only in the cycle after edge k+9, digits 2,5,5.
REQ-029 SHALL cover this scenario: bin=0, start -> digits 0,0,0 with a done pulse; bin=8'd109 -> digits 1,0,9; bin=8'd99 -> digits 0,9,9.
REQ-030 SHALL cover this scenario: start with bin=8'd42, then bin=8'd200 with start=1 at edge k+3 -> result 0,4,2, one done pulse only.
REQ-031 SHALL cover this scenario: start with bin=8'd77, rst at edge k+4 -> no done pulse, digits 0,0,0; a new start with bin=8'd77 -> digits 0,7,7.
REQ-032 SHALL cover this scenario, with BCD_AUTO_START_EN defined: bin changed 0->8'd150, start=0 -> done within 10 cycles, digits 1,5,0; bin held -> no further done pulse.
